// File: rtl/exposure_control_fsm_pkg.sv
// Shared encodings for the main camera FSM and the readout stage it drives.
`default_nettype none
package exposure_control_fsm_pkg;

  typedef enum logic [1:0] {
    MAIN_IDLE    = 2'b00,
    MAIN_EXPOSE  = 2'b01,
    MAIN_READOUT = 2'b10,
    MAIN_ERASE   = 2'b11
  } main_state_t;

  typedef enum logic [2:0] {
    RD_INIT    = 3'b000,
    RD_RESET   = 3'b001,
    RD_CHARGE  = 3'b010,
    RD_SAMPLE  = 3'b011,
    RD_CONVERT = 3'b100,
    RD_READ    = 3'b101,
    RD_END     = 3'b110
  } rd_state_t;

  localparam int EXP_W           = 5;
  localparam int CNT_W           = 10;
  localparam int EXP_MIN_DEF     = 2;
  localparam int EXP_MAX_DEF     = 30;
  localparam int EXP_DEFAULT_DEF = 15;

endpackage
`default_nettype wire

// File: rtl/exposure_control_fsm_exposure_reg.sv
// Button edge detection and saturating exposure-time register.
`default_nettype none
module exposure_reg
  import exposure_control_fsm_pkg::*;
#(
  parameter int EXP_MIN     = EXP_MIN_DEF,
  parameter int EXP_MAX     = EXP_MAX_DEF,
  parameter int EXP_DEFAULT = EXP_DEFAULT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             inc,
  input  logic             dec,
  output logic [EXP_W-1:0] exp_time
);

  logic inc_q;
  logic dec_q;
  logic inc_edge;
  logic dec_edge;

  assign inc_edge = inc & ~inc_q;
  assign dec_edge = dec & ~dec_q;

  // Edge registers track every cycle so presses outside the enable window are lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inc_q    <= 1'b0;
      dec_q    <= 1'b0;
      exp_time <= EXP_W'(EXP_DEFAULT);
    end else begin
      inc_q <= inc;
      dec_q <= dec;
      if (en) begin
        if (inc_edge && !dec_edge && (exp_time < EXP_W'(EXP_MAX)))
          exp_time <= exp_time + 1'b1;
        else if (dec_edge && !inc_edge && (exp_time > EXP_W'(EXP_MIN)))
          exp_time <= exp_time - 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/exposure_control_fsm.sv
// Main camera control FSM: ERASE -> EXPOSE -> READOUT -> IDLE with readout watchdog.
`default_nettype none
module exposure_control_fsm
  import exposure_control_fsm_pkg::*;
#(
  parameter int EXP_MIN       = EXP_MIN_DEF,
  parameter int EXP_MAX       = EXP_MAX_DEF,
  parameter int EXP_DEFAULT   = EXP_DEFAULT_DEF,
  parameter int CYCLES_PER_MS = 4,
  parameter int ERASE_CYCLES  = 2,
  parameter int RD_TIMEOUT    = 64
) (
  input  logic             i_Clock,
  input  logic             i_Reset,
  input  logic             i_Init,
  input  logic             i_Exp_increase,
  input  logic             i_Exp_decrease,
  input  logic [2:0]       i_RD_FSM,
  output logic [1:0]       o_Main_FSM,
  output logic             o_Erase,
  output logic             o_Expose,
  output logic [EXP_W-1:0] o_Exp_time,
  output logic             o_RD_timeout
);

  main_state_t      state;
  main_state_t      state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] exp_cycles;
  logic             timeout_hit;
  logic             adj_en;

  assign exp_cycles = CNT_W'(o_Exp_time) * CNT_W'(CYCLES_PER_MS);
  assign adj_en     = (state == MAIN_IDLE) && !i_Init;
  assign o_Main_FSM = state;

  exposure_reg #(
    .EXP_MIN     (EXP_MIN),
    .EXP_MAX     (EXP_MAX),
    .EXP_DEFAULT (EXP_DEFAULT)
  ) u_exposure_reg (
    .clk      (i_Clock),
    .rst      (i_Reset),
    .en       (adj_en),
    .inc      (i_Exp_increase),
    .dec      (i_Exp_decrease),
    .exp_time (o_Exp_time)
  );

  always_comb begin
    state_nxt   = state;
    timeout_hit = 1'b0;
    case (state)
      MAIN_IDLE:    if (i_Init) state_nxt = MAIN_ERASE;
      MAIN_ERASE:   if (cnt == CNT_W'(ERASE_CYCLES - 1)) state_nxt = MAIN_EXPOSE;
      MAIN_EXPOSE:  if (cnt == exp_cycles - 1'b1) state_nxt = MAIN_READOUT;
      MAIN_READOUT: begin
        if (i_RD_FSM == RD_END) begin
          state_nxt = MAIN_IDLE;
        end else if (cnt == CNT_W'(RD_TIMEOUT - 1)) begin
          state_nxt   = MAIN_IDLE;
          timeout_hit = 1'b1;
        end
      end
      default:      state_nxt = MAIN_IDLE;
    endcase
  end

  // Strobes decode next state so they line up with the registered state output.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state        <= MAIN_IDLE;
      cnt          <= '0;
      o_Erase      <= 1'b0;
      o_Expose     <= 1'b0;
      o_RD_timeout <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= (state_nxt != state) ? '0 : cnt + 1'b1;
      o_Erase  <= (state_nxt == MAIN_ERASE);
      o_Expose <= (state_nxt == MAIN_EXPOSE);
      if ((state == MAIN_IDLE) && i_Init)
        o_RD_timeout <= 1'b0;
      else if (timeout_hit)
        o_RD_timeout <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_exposure_control_fsm.sv
// Directed self-checking bench for exposure_control_fsm (watchdog shortened to 16 cycles).
`default_nettype none
module tb_exposure_control_fsm;

  logic       clk = 1'b0;
  logic       rst;
  logic       init = 1'b0;
  logic       inc = 1'b0;
  logic       dec = 1'b0;
  logic [2:0] rd_fsm = 3'b000;
  logic [1:0] main_fsm;
  logic       erase;
  logic       expose;
  logic [4:0] exp_time;
  logic       rd_timeout;

  int checks = 0;
  int failures = 0;
  int n;

  exposure_control_fsm #(
    .EXP_MIN       (2),
    .EXP_MAX       (30),
    .EXP_DEFAULT   (15),
    .CYCLES_PER_MS (4),
    .ERASE_CYCLES  (2),
    .RD_TIMEOUT    (16)
  ) dut (
    .i_Clock        (clk),
    .i_Reset        (rst),
    .i_Init         (init),
    .i_Exp_increase (inc),
    .i_Exp_decrease (dec),
    .i_RD_FSM       (rd_fsm),
    .o_Main_FSM     (main_fsm),
    .o_Erase        (erase),
    .o_Expose       (expose),
    .o_Exp_time     (exp_time),
    .o_RD_timeout   (rd_timeout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Counts cycles spent in state st, checking the strobes each cycle.
  task automatic run_phase(input logic [1:0] st, output int cnt);
    cnt = 0;
    while (main_fsm == st && cnt < 500) begin
      if (erase !== (st == 2'b11) || expose !== (st == 2'b01)) begin
        checks++;
        failures++;
        $error("FAIL strobe observed=%0d%0d expected=%0d%0d", erase, expose, st == 2'b11, st == 2'b01);
      end
      cnt++;
      tick();
    end
  endtask

  task automatic press(input bit up);
    if (up) inc = 1'b1; else dec = 1'b1;
    tick();
    inc = 1'b0;
    dec = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1;
    #2;
    chk("reset_main", main_fsm, 0);
    chk("reset_exp", exp_time, 15);
    chk("reset_strobes", {erase, expose, rd_timeout}, 0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Default sequence: 2 erase, 60 expose, END ends readout.
    init = 1'b1;
    tick();
    init = 1'b0;
    chk("start_erase", main_fsm, 3);
    chk("start_erase_strobe", erase, 1);
    run_phase(2'b11, n);
    chk("erase_len", n, 2);
    run_phase(2'b01, n);
    chk("expose_len_60", n, 60);
    chk("in_readout", main_fsm, 2);
    rd_fsm = 3'b110;
    tick();
    rd_fsm = 3'b000;
    chk("end_to_idle", main_fsm, 0);
    chk("no_timeout", rd_timeout, 0);

    // Saturating adjust.
    for (int i = 0; i < 20; i++) press(1'b1);
    chk("inc_sat_max", exp_time, 30);
    for (int i = 0; i < 40; i++) press(1'b0);
    chk("dec_sat_min", exp_time, 2);
    for (int i = 0; i < 6; i++) press(1'b1);
    chk("inc_six", exp_time, 8);
    inc = 1'b1;
    dec = 1'b1;
    tick();
    inc = 1'b0;
    dec = 1'b0;
    tick();
    chk("both_edges", exp_time, 8);
    inc = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    inc = 1'b0;
    tick();
    chk("held_inc", exp_time, 9);

    // Exposure 9 -> 36 cycles; button in EXPOSE and Init in READOUT ignored; watchdog fires.
    init = 1'b1;
    tick();
    init = 1'b0;
    run_phase(2'b11, n);
    chk("erase_len2", n, 2);
    inc = 1'b1;
    tick();
    inc = 1'b0;
    run_phase(2'b01, n);
    chk("expose_len_36", n + 1, 36);
    chk("exp_stable", exp_time, 9);
    init = 1'b1;
    tick();
    tick();
    init = 1'b0;
    chk("init_ignored", main_fsm, 2);
    run_phase(2'b10, n);
    chk("readout_timeout_len", n + 2, 16);
    chk("timeout_idle", main_fsm, 0);
    chk("timeout_flag", rd_timeout, 1);
    chk("exp_after_seq", exp_time, 9);
    tick();
    chk("no_queued_init", main_fsm, 0);
    chk("timeout_sticky", rd_timeout, 1);

    // Down to 7, start, then async reset mid-EXPOSE.
    press(1'b0);
    press(1'b0);
    chk("exp_seven", exp_time, 7);
    init = 1'b1;
    tick();
    init = 1'b0;
    chk("timeout_cleared", rd_timeout, 0);
    chk("erase_after_timeout", main_fsm, 3);
    tick();
    tick();
    for (int i = 0; i < 10; i++) tick();
    chk("mid_expose", {main_fsm, expose}, 3'b011);
    #2 rst = 1'b1;
    #1;
    chk("async_main", main_fsm, 0);
    chk("async_exp", exp_time, 15);
    chk("async_expose", expose, 0);
    tick();
    rst = 1'b0;
    tick();

    // Init and button edge together: Init wins.
    init = 1'b1;
    inc = 1'b1;
    tick();
    init = 1'b0;
    inc = 1'b0;
    chk("init_wins", main_fsm, 3);
    chk("init_wins_exp", exp_time, 15);
    run_phase(2'b11, n);
    run_phase(2'b01, n);
    chk("expose_after_reset", n, 60);
    rd_fsm = 3'b110;
    tick();
    rd_fsm = 3'b000;
    chk("final_idle", main_fsm, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
